// File: rtl/ifid_skid_buffer_pkg.sv
// Shared ISA constants for the IF/ID boundary: NOP encoding, named opcodes and the
// ImmdLocation select encoding consumed by the sign extender.
package isa_pkg;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b01000;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    IMMD_5B   = 2'd0,
    IMMD_8B   = 2'd1,
    IMMD_11B  = 2'd2,
    IMMD_BIT0 = 2'd3
  } immd_loc_e;

endpackage

// File: rtl/ifid_skid_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID skid buffer.
// The slave modport is the buffer itself; master is the surrounding pipeline.
interface ifid_skid_buffer_if #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16
);
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc_inc;
  logic               flush;
  logic               id_stall;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc_inc;
  logic [1:0]         id_immd_loc;
  logic [1:0]         occupancy;

  modport slave (
    input  if_valid, if_instr, if_pc_inc, flush, id_stall,
    output if_ready, id_valid, id_instr, id_pc_inc, id_immd_loc, occupancy
  );

  modport master (
    output if_valid, if_instr, if_pc_inc, flush, id_stall,
    input  if_ready, id_valid, id_instr, id_pc_inc, id_immd_loc, occupancy
  );
endinterface

// File: rtl/ifid_skid_buffer_immd_loc_decoder.sv
// Opcode to ImmdLocation select; purely combinational so the hazard unit can reuse it.
module immd_loc_decoder
  import isa_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [1:0] loc
);
  immd_loc_e loc_e;

  always_comb begin
    loc_e = IMMD_BIT0;
    unique case (opcode)
      OP_ADDI, 5'b01001, 5'b01010, 5'b01011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111,
      5'b10000, 5'b10001, 5'b10011:             loc_e = IMMD_5B;
      5'b01100, 5'b01101, 5'b01110, 5'b01111,
      5'b11000, 5'b10010, 5'b00101, 5'b00111:   loc_e = IMMD_8B;
      OP_J, 5'b00110:                           loc_e = IMMD_11B;
      OP_HALT, OP_NOP:                          loc_e = IMMD_BIT0;
      default:                                  loc_e = IMMD_BIT0;
    endcase
  end

  assign loc = loc_e;
endmodule

// File: rtl/ifid_skid_buffer.sv
// IF/ID skid buffer: two registered entries addressed by toggling rd/wr pointer bits,
// flush on redirect, NOP presented to decode whenever the buffer is empty.
module ifid_skid_buffer
  import isa_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16,
  parameter int DEPTH   = 2
) (
  input logic              clk,
  input logic              rst,
  ifid_skid_buffer_if.slave bus
);
  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [1:0]         count_q, count_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [INSTR_W-1:0] instr_q [2];
  logic [INSTR_W-1:0] instr_d [2];
  logic [PC_W-1:0]    pc_q [2];
  logic [PC_W-1:0]    pc_d [2];
  logic               push, pop;

  assign bus.if_ready = (count_q < FULL);
  assign push = bus.if_valid && bus.if_ready && !bus.flush;
  assign pop  = bus.id_valid && !bus.id_stall && !bus.flush;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    if (bus.flush) begin
      count_d  = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = bus.if_instr;
        pc_d[wr_ptr_q]    = bus.if_pc_inc;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      instr_q  <= '{default: '0};
      pc_q     <= '{default: '0};
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
    end
  end

  assign bus.id_valid  = (count_q != 2'd0);
  assign bus.occupancy = count_q;
  // Stale payload stays in the entries after a pop; emptiness is masked here instead.
  assign bus.id_instr  = bus.id_valid ? instr_q[rd_ptr_q] : INSTR_W'(NOP_INSTR);
  assign bus.id_pc_inc = bus.id_valid ? pc_q[rd_ptr_q] : '0;

  immd_loc_decoder u_immd_loc_decoder (
    .opcode (bus.id_instr[INSTR_W-1 -: 5]),
    .loc    (bus.id_immd_loc)
  );
endmodule

// File: tb/tb_ifid_skid_buffer.sv
// Scoreboard bench for ifid_skid_buffer: a queue models the buffer contents and every
// output is compared on the falling edge against the queue head.
module tb_ifid_skid_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifid_skid_buffer_if #(.INSTR_W(16), .PC_W(16)) bus ();

  ifid_skid_buffer #(.INSTR_W(16), .PC_W(16), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } entry_t;

  entry_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit primed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_loc(input logic [4:0] op);
    case (op)
      5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10100, 5'b10101,
      5'b10110, 5'b10111, 5'b10000, 5'b10001, 5'b10011: return 2'b00;
      5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000,
      5'b10010, 5'b00101, 5'b00111:                     return 2'b01;
      5'b00100, 5'b00110:                               return 2'b10;
      default:                                          return 2'b11;
    endcase
  endfunction

  // Check the state visible before the next rising edge, then predict that edge.
  always @(negedge clk) begin
    int sz;
    bit do_pop, do_push;
    sz = exp_q.size();
    if (primed) begin
      chk("occupancy", 32'(bus.occupancy), 32'(sz));
      chk("if_ready", 32'(bus.if_ready), 32'(sz < 2));
      chk("id_valid", 32'(bus.id_valid), 32'(sz != 0));
      if (sz == 0) begin
        chk("nop_instr", 32'(bus.id_instr), 32'h0800);
        chk("nop_pc", 32'(bus.id_pc_inc), 32'h0);
        chk("nop_loc", 32'(bus.id_immd_loc), 32'd3);
      end else begin
        chk("head_instr", 32'(bus.id_instr), 32'(exp_q[0].instr));
        chk("head_pc", 32'(bus.id_pc_inc), 32'(exp_q[0].pc));
        chk("head_loc", 32'(bus.id_immd_loc), 32'(exp_loc(exp_q[0].instr[15:11])));
      end
    end
    if (rst) begin
      exp_q.delete();
      primed = 1'b1;
    end else if (primed) begin
      if (bus.flush) begin
        exp_q.delete();
      end else begin
        do_pop  = (sz != 0) && !bus.id_stall;
        do_push = bus.if_valid && (sz < 2);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back('{instr: bus.if_instr, pc: bus.if_pc_inc});
      end
    end
  end

  task automatic cyc(input bit v, input logic [15:0] ins, input logic [15:0] pc,
                     input bit stall, input bit fl, input bit r);
    bus.if_valid  = v;
    bus.if_instr  = ins;
    bus.if_pc_inc = pc;
    bus.id_stall  = stall;
    bus.flush     = fl;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc_inc = '0;
    bus.id_stall = 1'b0; bus.flush = 1'b0; rst = 1'b1;
    #1;
    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      cyc(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    cyc(0, 16'h0, 16'h0, 0, 0, 0);

    // Streaming
    cyc(1, 16'h4123, 16'h0002, 0, 0, 0);
    cyc(1, 16'h2405, 16'h0004, 0, 0, 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 0);

    // Stall fill, third word held by fetch until accepted
    cyc(1, 16'h6010, 16'h0006, 1, 0, 0);
    cyc(1, 16'hC0FF, 16'h0008, 1, 0, 0);
    cyc(1, 16'h5A5A, 16'h000A, 1, 0, 0);
    cyc(1, 16'h5A5A, 16'h000A, 1, 0, 0);
    cyc(1, 16'h5A5A, 16'h000A, 0, 0, 0);
    cyc(1, 16'h5A5A, 16'h000A, 0, 0, 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 0);

    // Simultaneous push/pop at count=1
    cyc(1, 16'h3001, 16'h0010, 0, 0, 0);
    cyc(1, 16'h9802, 16'h0012, 0, 0, 0);
    cyc(1, 16'h0000, 16'h0014, 0, 0, 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 0);

    // Flush at count=2 with a word offered
    cyc(1, 16'h7111, 16'h0020, 1, 0, 0);
    cyc(1, 16'h3222, 16'h0022, 1, 0, 0);
    cyc(1, 16'hA333, 16'h0024, 1, 1, 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 0);

    // Reset mid-stream at count=2, then first post-reset push
    cyc(1, 16'h8444, 16'h0030, 1, 0, 0);
    cyc(1, 16'hB555, 16'h0032, 1, 0, 0);
    cyc(1, 16'hE666, 16'h0034, 0, 0, 1);
    cyc(1, 16'h2777, 16'h0036, 0, 0, 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 49) == 0));
    cyc(0, 16'h0, 16'h0, 0, 0, 0);
    cyc(0, 16'h0, 16'h0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ifid_skid_buffer.md
Name: ifid_skid_buffer

Overview:
- IF/ID pipeline boundary: a 2-entry skid buffer between instruction fetch and decode.
- Captures the fetched instruction word and PC+2, absorbs decode stalls without dropping a word, and flushes on branch/jump redirect.
- Pre-decodes the immediate-format select, so the sign extender's ImmdLocation input comes straight from a register-backed path.

Parameters:
- INSTR_W, 16, instruction word width
- PC_W, 16, width of incremented PC
- DEPTH, 2, buffer entries; fixed at 2, other values unsupported

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- if_valid  in  1  fetch presents a word this cycle
- if_ready  out  1  buffer can accept a word this cycle
- if_instr  in  INSTR_W  fetched instruction
- if_pc_inc  in  PC_W  PC+2 of fetched instruction
- flush  in  1  discard all buffered words (redirect)
- id_stall  in  1  decode cannot consume the head this cycle
- id_valid  out  1  head entry holds a real instruction
- id_instr  out  INSTR_W  head instruction, or NOP when empty
- id_pc_inc  out  PC_W  head PC+2, or 0 when empty
- id_immd_loc  out  2  immediate-format select for the sign extender
- occupancy  out  2  entries held, 0..2

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset state:
  - count=0, rd_ptr=wr_ptr=0.
  - Outputs after reset: id_valid=0, id_instr=16'h0800 (NOP, opcode 00001), id_pc_inc=0, id_immd_loc=2'b11, if_ready=1, occupancy=0.
  - rst overrides every other input.
- if_ready = (count < 2). It depends only on registered state, never combinationally on id_stall.
- Push: if_valid && if_ready && !flush. The entry is written at wr_ptr, then wr_ptr toggles.
- Pop: id_valid && !id_stall && !flush. rd_ptr toggles.
- Count update:
  - Push and pop in the same cycle: count unchanged.
  - Push only: +1.
  - Pop only: -1.
  - Count never exceeds 2 and never underflows.
- Flush:
  - Next cycle count=0 and both pointers=0.
  - Flush beats push in the same cycle; the word offered that cycle is dropped.
  - Flush is legal at any occupancy and during id_stall.
- Latency: a word accepted at edge N is on the id_* outputs immediately after edge N, so decode sees it in cycle N+1.
- Outputs:
  - id_valid = (count != 0).
  - id_instr and id_pc_inc come from the entry at rd_ptr.
  - When count==0, id_instr is forced to NOP and id_pc_inc to 0.
  - The payload registers are not cleared on pop.
- id_immd_loc, decoded from the opcode id_instr[15:11] of the head (the NOP when empty):
  - 2'b00 (5-bit): 01000, 01001, 01010, 01011, 10100, 10101, 10110, 10111, 10000, 10001, 10011
  - 2'b01 (8-bit): 01100, 01101, 01110, 01111, 11000, 10010, 00101, 00111
  - 2'b10 (11-bit): 00100, 00110
  - 2'b11: every other opcode, including NOP and HALT 00000
- Ordering: strict FIFO; there is never any reordering or duplication.
- Stall with count==2: if_ready=0 and fetch must hold its word. The buffer ignores if_instr while if_ready=0.
- occupancy = count.

Decomposition:
- Shared package isa_pkg:
  - opcode constants
  - NOP_INSTR = 16'h0800
  - immediate-select encodings IMMD_5B=0, IMMD_8B=1, IMMD_11B=2, IMMD_BIT0=3
- The same ImmdLocation encoding is used by the existing sign extender's selector.
- One sub-module, immd_loc_decoder: purely combinational, opcode[4:0] in, loc[1:0] out, reused later by the hazard unit.
- Storage is two registered entries with pointer bits; no other sub-modules.

Test Plan:
- Reset with rst=1 for 2 cycles, all inputs random -> id_valid=0, id_instr=16'h0800, id_immd_loc=2'b11, if_ready=1, occupancy=0.
- Streaming: push 16'h4123 (ADDI, pc_inc 16'h0002) then 16'h2405 (J, pc_inc 16'h0004), id_stall=0 ->
  - cycle after first push: id_instr=16'h4123, id_immd_loc=2'b00;
  - next cycle: 16'h2405, id_immd_loc=2'b10;
  - occupancy stays ≤1.
- Stall fill: id_stall=1, push 16'h6010 then 16'hC0FF ->
  - occupancy=2, if_ready=0;
  - a third word offered is not taken;
  - release stall -> 16'h6010 (loc 01) then 16'hC0FF (loc 01), then the third word, in order.
- Simultaneous push/pop at count=1 -> occupancy stays 1, head advances to the newly pushed word one cycle later.
- Flush at count=2 with if_valid=1 in the same cycle -> next cycle occupancy=0, id_valid=0, id_instr=16'h0800, offered word dropped.
- rst asserted mid-stream at count=2 -> next cycle identical to the post-reset state, and the first post-reset push appears one cycle after acceptance.
